// File: rtl/ram_requester_pkg.sv
// Shared helpers for the RAM requester slice.
package ram_requester_pkg;

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_requester_fifo.sv
// Response FIFO: push/pop, occupancy count and head data. Storage is not reset.
module ram_requester_fifo
  import ram_requester_pkg::*;
#(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock0,
  input  logic                       aclr0_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [ptr_bits(DEPTH):0]   count,
  output logic [WIDTH-1:0]           head_data
);

  localparam int unsigned PW = ptr_bits(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;

  // Next-state: pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clock0 or negedge aclr0_n) begin
    if (!aclr0_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage, written on push only.
  always_ff @(posedge clock0) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Outputs.
  always_comb begin
    count     = count_q;
    head_data = mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/ram_requester.sv
// Request sequencer for one RAM port: drives address/wren/data, captures q one
// cycle after a read and returns read data in order through a response FIFO.
module ram_requester
  import ram_requester_pkg::*;
#(
  parameter int unsigned WIDTHAD = 12,
  parameter int unsigned WIDTH   = 28,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clock0,
  input  logic               aclr0_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [WIDTHAD-1:0] req_addr,
  input  logic [WIDTH-1:0]   req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [WIDTHAD-1:0] address,
  output logic               wren,
  output logic [WIDTH-1:0]   data,
  input  logic [WIDTH-1:0]   q
);

  localparam int unsigned PW = ptr_bits(DEPTH);

  logic          pending_q, pending_d;
  logic          live_q;
  logic          accept;
  logic          pop;
  logic [PW:0]   count;
  logic [PW+1:0] occupancy;

  // Ready reserves a slot for the read in flight; held low until out of reset.
  always_comb begin
    occupancy = {1'b0, count} + {{(PW + 1){1'b0}}, pending_q};
    req_ready = live_q && (occupancy < (PW + 2)'(DEPTH));
    accept    = req_valid & req_ready;
    wren      = accept & req_write;
    address   = req_addr;
    data      = req_data;
    pending_d = accept & ~req_write;
    rsp_valid = (count != '0);
    pop       = rsp_valid & rsp_ready;
  end

  // Read-in-flight flag and out-of-reset marker.
  always_ff @(posedge clock0 or negedge aclr0_n) begin
    if (!aclr0_n) begin
      pending_q <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      live_q    <= 1'b1;
    end
  end

  ram_requester_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock0    (clock0),
    .aclr0_n   (aclr0_n),
    .push      (pending_q),
    .pop       (pop),
    .push_data (q),
    .count     (count),
    .head_data (rsp_data)
  );

endmodule

// File: tb/tb_ram_requester.sv
// Self-checking bench: RAM model plus a transaction-level reference model.
module tb_ram_requester;

  localparam int unsigned WIDTHAD = 12;
  localparam int unsigned WIDTH   = 28;
  localparam int unsigned DEPTH   = 4;

  logic               clock0 = 1'b0;
  logic               aclr0_n;
  logic               req_valid, req_ready, req_write;
  logic [WIDTHAD-1:0] req_addr;
  logic [WIDTH-1:0]   req_data;
  logic               rsp_valid, rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic [WIDTHAD-1:0] address;
  logic               wren;
  logic [WIDTH-1:0]   data;
  logic [WIDTH-1:0]   q;

  ram_requester #(
    .WIDTHAD (WIDTHAD),
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH)
  ) dut (
    .clock0    (clock0),
    .aclr0_n   (aclr0_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .address   (address),
    .wren      (wren),
    .data      (data),
    .q         (q)
  );

  always #5 clock0 = ~clock0;

  // Synchronous RAM port: registered address, q follows one cycle later.
  logic [WIDTH-1:0]   ram [1 << WIDTHAD];
  logic [WIDTHAD-1:0] ram_addr_q;
  always @(posedge clock0) begin
    if (wren) ram[address] <= data;
    ram_addr_q <= address;
  end
  assign q = ram[ram_addr_q];

  // Reference model: memory contents and outstanding reads with due cycle.
  typedef struct packed {
    logic [WIDTH-1:0] d;
    int               due;
  } rsp_t;

  logic [WIDTH-1:0] mdl_mem [16];
  rsp_t             exp_q [$];
  bit               awake;
  int               cyc;
  int               n_checks;
  int               n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one cycle of stimulus, check outputs, advance model and clock.
  task automatic step(input bit v, input bit w, input logic [WIDTHAD-1:0] a,
                      input logic [WIDTH-1:0] d, input bit rr);
    bit   exp_ready, exp_valid, acc;
    rsp_t ent;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    rsp_ready = rr;
    #1;
    exp_ready = awake && (exp_q.size() < DEPTH);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    acc       = v && exp_ready;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) check("rsp_data", 32'(rsp_data), 32'(exp_q[0].d));
    check("wren", 32'(wren), 32'(acc && w));
    check("address", 32'(address), 32'(a));
    if (exp_valid && rr) ent = exp_q.pop_front();
    if (acc && !w) exp_q.push_back('{d: mdl_mem[a[3:0]], due: cyc + 2});
    if (acc && w) mdl_mem[a[3:0]] = d;
    @(negedge clock0);
    cyc++;
    awake = 1'b1;
  endtask

  // Hold reset for three cycles with a write request pending; all outputs idle.
  task automatic do_reset();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = '0;
    req_data  = '1;
    rsp_ready = 1'b1;
    aclr0_n   = 1'b0;
    exp_q.delete();
    awake = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_wren", 32'(wren), 32'd0);
      @(negedge clock0);
      cyc++;
    end
    aclr0_n   = 1'b1;
    req_valid = 1'b0;
    // First edge after release brings req_ready up.
    @(negedge clock0);
    cyc++;
    awake = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    awake    = 1'b0;
    aclr0_n  = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    @(negedge clock0);
    do_reset();

    // Write 0x5 to address 3, then read it back.
    step(1, 1, 12'd3, 28'h5, 1);
    step(1, 0, 12'd3, 28'h0, 1);
    repeat (3) step(0, 0, 12'd0, 28'h0, 1);

    // Preload 0..15 with i+0x10, address 5 gets 0x11.
    for (int i = 0; i < 16; i++) step(1, 1, 12'(i), 28'(i + 'h10), 1);
    step(1, 1, 12'd5, 28'h11, 1);

    // Back-to-back reads 0..7 with rsp_ready high.
    for (int i = 0; i < 8; i++) step(1, 0, 12'(i), 28'h0, 1);
    repeat (3) step(0, 0, 12'd0, 28'h0, 1);

    // Back-pressure: only DEPTH reads accepted, then drain.
    for (int i = 0; i < 7; i++) step(1, 0, 12'(i + 8), 28'h0, 0);
    repeat (6) step(0, 0, 12'd0, 28'h0, 1);

    // Read 5, then overwrite 5, then read 5 again.
    step(1, 0, 12'd5, 28'h0, 1);
    step(1, 1, 12'd5, 28'h22, 1);
    step(1, 0, 12'd5, 28'h0, 1);
    repeat (3) step(0, 0, 12'd0, 28'h0, 1);

    // Reset while a read is in flight: it must never respond.
    step(1, 0, 12'd7, 28'h0, 1);
    do_reset();
    repeat (4) step(0, 0, 12'd0, 28'h0, 1);

    // Randomized traffic over the preloaded window.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           12'($urandom_range(0, 15)), 28'($urandom), ($urandom_range(0, 3) != 0));
      if (i == 200) do_reset();
    end
    repeat (6) step(0, 0, 12'd0, 28'h0, 1);
    check("drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
